// File: rtl/mdio_phy_mgr.sv
// mdio_phy_mgr: PHY init, link polling and host register access sequencer for mdio_ct
module mdio_phy_mgr #(
  parameter logic [4:0] PHY_ADDR = 5'd0,
  parameter int POLL_INTERVAL = 1000000,
  parameter int RST_TRIES = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cyc_o,
  output logic        we_o,
  output logic [4:0]  phy_adr_o,
  output logic [4:0]  reg_adr_o,
  output logic [15:0] tx_dat_o,
  input  logic        ack_i,
  input  logic [15:0] rx_dat_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [4:0]  host_reg_i,
  input  logic [15:0] host_wdat_i,
  output logic        host_ack_o,
  output logic [15:0] host_rdat_o,
  output logic        init_done_o,
  output logic        init_err_o,
  output logic        link_up_o,
  output logic        speed_o,
  output logic        fdx_o
);
  localparam int IW = $clog2(POLL_INTERVAL);
  localparam int TW = $clog2(RST_TRIES + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {S_RST_WR, S_RST_RD, S_AN_WR, S_WAIT, S_BMSR, S_LPA, S_HOST, S_ERR} state_t;
  state_t state_q, state_d;
  logic cyc_q, cyc_d, we_q, we_d;
  logic [4:0] reg_q, reg_d;
  logic [15:0] tx_q, tx_d;
  logic [AW-1:0] ack_cnt_q, ack_cnt_d;
  logic [IW-1:0] ivl_q, ivl_d;
  logic [TW-1:0] tries_q, tries_d;
  logic host_ack_q, host_ack_d;
  logic [15:0] host_rdat_q, host_rdat_d;
  logic done_q, done_d, err_q, err_d, link_q, link_d, spd_q, spd_d, fdx_q, fdx_d;
  logic xact, req_we, host_go, xact_done, timeout, bmsr_link;
  logic [4:0] req_reg;
  logic [15:0] req_dat;
  assign xact = state_q inside {S_RST_WR, S_RST_RD, S_AN_WR, S_BMSR, S_LPA, S_HOST};
  assign req_we = state_q == S_RST_WR || state_q == S_AN_WR || (state_q == S_HOST && host_we_i);
  assign req_reg = state_q == S_BMSR ? 5'd1 : state_q == S_LPA ? 5'd5 : state_q == S_HOST ? host_reg_i : 5'd0;
  assign req_dat = state_q == S_RST_WR ? 16'h8000 : state_q == S_AN_WR ? 16'h1200 : state_q == S_HOST ? host_wdat_i : 16'h0000;
  assign xact_done = cyc_q & ack_i;
  assign timeout = cyc_q & ~ack_i & (ack_cnt_q == AW'(ACK_TIMEOUT - 1));
  assign host_go = host_req_i & ~host_ack_q;
  assign bmsr_link = rx_dat_i[2] & rx_dat_i[5];
  always_comb begin
    state_d = state_q;
    cyc_d = cyc_q;
    we_d = we_q;
    reg_d = reg_q;
    tx_d = tx_q;
    ack_cnt_d = cyc_q ? ack_cnt_q + 1'b1 : '0;
    ivl_d = ivl_q;
    tries_d = tries_q;
    host_ack_d = 1'b0;
    host_rdat_d = host_rdat_q;
    done_d = done_q;
    err_d = err_q;
    link_d = link_q;
    spd_d = spd_q;
    fdx_d = fdx_q;
    if (xact && !cyc_q) begin
      cyc_d = 1'b1;
      we_d = req_we;
      reg_d = req_reg;
      tx_d = req_dat;
    end
    if (xact_done) cyc_d = 1'b0;
    case (state_q)
      S_RST_WR: if (xact_done) begin
        state_d = S_RST_RD;
        tries_d = '0;
      end
      S_RST_RD: if (xact_done) begin
        if (!rx_dat_i[15]) state_d = S_AN_WR;
        else if (tries_q == TW'(RST_TRIES - 1)) begin
          state_d = S_ERR;
          err_d = 1'b1;
        end else tries_d = tries_q + 1'b1;
      end
      S_AN_WR: if (xact_done) begin
        state_d = S_WAIT;
        done_d = 1'b1;
        ivl_d = '0;
      end
      S_WAIT: begin
        if (host_go) state_d = S_HOST;
        else if (ivl_q == IW'(POLL_INTERVAL - 1)) state_d = S_BMSR;
        else ivl_d = ivl_q + 1'b1;
      end
      S_BMSR: if (xact_done) begin
        state_d = bmsr_link ? S_LPA : S_WAIT;
        ivl_d = '0;
        link_d = bmsr_link & link_q;
        spd_d = bmsr_link & spd_q;
        fdx_d = bmsr_link & fdx_q;
      end
      S_LPA: if (xact_done) begin
        state_d = S_WAIT;
        ivl_d = '0;
        link_d = 1'b1;
        spd_d = rx_dat_i[8] | rx_dat_i[7];
        fdx_d = rx_dat_i[8] | (~rx_dat_i[7] & rx_dat_i[6]);
      end
      S_HOST: if (xact_done) begin
        state_d = err_q ? S_ERR : S_WAIT;
        host_ack_d = 1'b1;
        host_rdat_d = we_q ? 16'hFFFF : rx_dat_i;
      end
      S_ERR: if (host_go) state_d = S_HOST;
      default: ;
    endcase
    if (timeout) begin
      cyc_d = 1'b0;
      err_d = 1'b1;
      state_d = S_ERR;
    end
    if (state_d == S_ERR) begin
      link_d = 1'b0;
      spd_d = 1'b0;
      fdx_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST_WR;
      cyc_q <= 1'b0;
      we_q <= 1'b0;
      reg_q <= '0;
      tx_q <= '0;
      ack_cnt_q <= '0;
      ivl_q <= '0;
      tries_q <= '0;
      host_ack_q <= 1'b0;
      host_rdat_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      link_q <= 1'b0;
      spd_q <= 1'b0;
      fdx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      we_q <= we_d;
      reg_q <= reg_d;
      tx_q <= tx_d;
      ack_cnt_q <= ack_cnt_d;
      ivl_q <= ivl_d;
      tries_q <= tries_d;
      host_ack_q <= host_ack_d;
      host_rdat_q <= host_rdat_d;
      done_q <= done_d;
      err_q <= err_d;
      link_q <= link_d;
      spd_q <= spd_d;
      fdx_q <= fdx_d;
    end
  end
  assign cyc_o = cyc_q;
  assign we_o = we_q;
  assign phy_adr_o = PHY_ADDR;
  assign reg_adr_o = reg_q;
  assign tx_dat_o = tx_q;
  assign host_ack_o = host_ack_q;
  assign host_rdat_o = host_rdat_q;
  assign init_done_o = done_q;
  assign init_err_o = err_q;
  assign link_up_o = link_q;
  assign speed_o = spd_q;
  assign fdx_o = fdx_q;
endmodule
